// File: rtl/vga_scan_timing.sv
// Raster scan timing for the VGA output: pixel/line counters, sync/blank decode,
// per-frame update strobe and sync/blank copies delayed to meet the registered colour.
module vga_scan_timing #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       bright,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       frame_tick,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       blank_n_o
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] Y_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Idle pattern for the delay line: syncs inactive, blanked.
    localparam logic [2:0] PIPE_RESET = 3'b110;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;

    logic [2:0] pipe_q [PIPE_DELAY];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        x_d       = x_q;
        y_d       = y_q;
        if (pixel_tick) begin
            div_cnt_d = '0;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_comb begin
        pixel_tick = (div_cnt_q == DIV_LAST);
        bright     = (x_q < X_VIS) && (y_q < Y_VIS);
        hsync      = !((x_q >= HS_START) && (x_q < HS_END));
        vsync      = !((y_q >= VS_START) && (y_q < VS_END));
        frame_tick = pixel_tick && (x_q == X_LAST) && (y_q == Y_VIS_LAST);
    end

    assign x = x_q;
    assign y = y_q;

    // Sampled every clk so the delay is in clks, not pixels.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe_q[i] <= PIPE_RESET;
            end
        end else begin
            pipe_q[0] <= {hsync, vsync, bright};
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {hsync_o, vsync_o, blank_n_o} = pipe_q[PIPE_DELAY-1];

endmodule
